// File: rtl/ycpu_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, FSM states, ALU ops.
// No latency (declarations only).
// No backpressure (declarations only).
package ycpu_pkg;

  localparam logic [6:0] OPC_R     = 7'h33;
  localparam logic [6:0] OPC_I     = 7'h13;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_JAL   = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_I     = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_BR    = 3'd4,
    CLS_JAL   = 3'd5,
    CLS_ILL   = 3'd6
  } cls_t;

  // Map the major opcode to an instruction class; anything unknown is illegal.
  function automatic cls_t decode_class(input logic [6:0] opc);
    case (opc)
      OPC_R:     return CLS_R;
      OPC_I:     return CLS_I;
      OPC_LOAD:  return CLS_LOAD;
      OPC_STORE: return CLS_STORE;
      OPC_BR:    return CLS_BR;
      OPC_JAL:   return CLS_JAL;
      default:   return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/ymc_ctrl_if.sv
// Bundle between the controller and the yIF/yID/yEX/memory datapath.
// No latency (wires only).
// No backpressure beyond mem_ready, which the controller waits on.
interface ymc_ctrl_if #(parameter int XLEN = 32);

  logic            run;
  logic [31:0]     ins;
  logic            zero;
  logic [XLEN-1:0] branch;
  logic [XLEN-1:0] jTarget;
  logic            mem_ready;

  logic [XLEN-1:0] pc;
  logic            ir_we;
  logic            RegWrite;
  logic            ALUSrc;
  logic            Mem2Reg;
  logic            MemRead;
  logic            MemWrite;
  logic [2:0]      op;
  logic [31:0]     retired;
  logic            trap;

  modport master (
    input  run, ins, zero, branch, jTarget, mem_ready,
    output pc, ir_we, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op, retired, trap
  );

  modport slave (
    output run, ins, zero, branch, jTarget, mem_ready,
    input  pc, ir_we, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op, retired, trap
  );

endinterface

// File: rtl/ymc_pc.sv
// Program counter register with next-PC selection (jal target, taken branch, pc+4).
// Updates on the retire edge; holds otherwise.
// No backpressure: i_retire is the only enable.
module ymc_pc #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h28)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_retire,
  input  logic            i_jal,
  input  logic            i_br,
  input  logic            i_zero,
  input  logic [XLEN-1:0] i_branch,
  input  logic [XLEN-1:0] i_jtarget,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next;

  // Next-PC mux; the adder wraps naturally modulo 2^XLEN.
  always_comb begin
    w_next = r_pc + XLEN'(4);
    if (i_jal) begin
      w_next = i_jtarget;
    end else if (i_br && i_zero) begin
      w_next = i_branch;
    end
  end

  // PC only moves when an instruction retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_retire) begin
      r_pc <= w_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ymc_ctrl.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing, PC and retire count.
// 3 to 5 cycles per instruction plus memory wait cycles; controls decode combinationally from state and IR.
// Stalls in MEM while mem_ready is low, trapping after MEM_TIMEOUT unanswered cycles.
module ymc_ctrl
  import ycpu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h28),
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  ymc_ctrl_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  state_t            r_state;
  logic [31:0]       r_ir;
  logic [WAIT_W-1:0] r_wait;
  logic [31:0]       r_retired;

  cls_t w_cls;
  logic w_retire;
  logic w_unused_ir;

  assign w_cls       = decode_class(r_ir[6:0]);
  assign w_unused_ir = ^r_ir[31:7];

  // Retire fires on the edge that leaves an instruction's last state.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      EXEC:    w_retire = (w_cls == CLS_BR);
      MEM:     w_retire = (w_cls == CLS_STORE) && bus.mem_ready;
      WB:      w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  // Main sequencer: state, IR, MEM wait counter and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_ir      <= '0;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + 32'd1;
      end
      case (r_state)
        FETCH: begin
          r_ir <= bus.ins;
          if (bus.run) begin
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_state <= (w_cls == CLS_ILL) ? TRAP : EXEC;
        end
        EXEC: begin
          case (w_cls)
            CLS_BR:              r_state <= FETCH;
            CLS_LOAD, CLS_STORE: begin
              r_state <= MEM;
              r_wait  <= '0;
            end
            CLS_ILL:             r_state <= TRAP;
            default:             r_state <= WB;
          endcase
        end
        MEM: begin
          // A ready on the final allowed cycle still completes the access.
          if (bus.mem_ready) begin
            r_state <= (w_cls == CLS_LOAD) ? WB : FETCH;
          end else if (r_wait == WAIT_W'(MEM_TIMEOUT - 1)) begin
            r_state <= TRAP;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        WB:      r_state <= FETCH;
        TRAP:    r_state <= TRAP;
        default: r_state <= TRAP;
      endcase
    end
  end

  // Datapath controls from state and IR class; reset forces FETCH so MEM strobes drop at once.
  always_comb begin
    bus.ir_we    = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.Mem2Reg  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.op       = 3'b000;
    bus.trap     = 1'b0;
    case (r_state)
      FETCH: bus.ir_we = rst_n;
      EXEC, MEM, WB: begin
        bus.op     = (w_cls == CLS_BR) ? ALU_SUB : ALU_ADD;
        bus.ALUSrc = !((w_cls == CLS_R) || (w_cls == CLS_BR));
        if (r_state == MEM) begin
          bus.MemRead  = (w_cls == CLS_LOAD);
          bus.MemWrite = (w_cls == CLS_STORE);
        end
        if (r_state == WB) begin
          bus.RegWrite = 1'b1;
          bus.Mem2Reg  = (w_cls == CLS_LOAD);
        end
      end
      TRAP:    bus.trap = 1'b1;
      default: bus.trap = 1'b0;
    endcase
  end

  assign bus.retired = r_retired;

  ymc_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_retire  (w_retire),
    .i_jal     (w_cls == CLS_JAL),
    .i_br      (w_cls == CLS_BR),
    .i_zero    (bus.zero),
    .i_branch  (bus.branch),
    .i_jtarget (bus.jTarget),
    .o_pc      (bus.pc)
  );

endmodule
